// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus a latency scoreboard that stalls consumers of multi-cycle results.
// Define FWD_ZERO_REG_EN to make register 0 a hardwired zero (never forwarded, tracked or stalled on).
module fwd_hazard_unit #(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 4,
   parameter int STALL_CW = 16,
   localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      ex_valid,
   input  logic [NUM_SRC*REG_AW-1:0] ex_src,
   input  logic                      mem_regwrite,
   input  logic [REG_AW-1:0]         mem_wreg,
   input  logic                      wb_regwrite,
   input  logic [REG_AW-1:0]         wb_wreg,
   input  logic                      iss_valid,
   input  logic [REG_AW-1:0]         iss_wreg,
   input  logic [LAT_W-1:0]          iss_lat,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      stall,
   output logic [STALL_CW-1:0]       stall_cycles
);

   localparam int NUM_REG = 2 ** REG_AW;

   logic [LAT_W-1:0] cnt [NUM_REG];
   logic [LAT_W-1:0] lat_ld;
   logic             load;

   function automatic logic live(input logic [REG_AW-1:0] r);
`ifdef FWD_ZERO_REG_EN
      live = (r != '0);
`else
      live = 1'b1;
`endif
   endfunction

   always_comb begin
      logic [REG_AW-1:0] src;
      logic              mem_hit;
      logic              wb_hit;
      fwd_sel = '0;
      stall   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src     = ex_src[i*REG_AW +: REG_AW];
         mem_hit = mem_regwrite && live(mem_wreg) && (mem_wreg == src);
         wb_hit  = wb_regwrite && live(wb_wreg) && (wb_wreg == src);
         if (mem_hit)
            fwd_sel[2*i +: 2] = 2'b10;
         else if (wb_hit)
            fwd_sel[2*i +: 2] = 2'b01;
         if (ex_valid && live(src) && (cnt[src] != '0))
            stall = 1'b1;
      end
   end

   assign lat_ld = (iss_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : iss_lat;
   assign load   = iss_valid && !stall && live(iss_wreg);

   // a fresh issue overrides the countdown of the same register
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REG; r++) begin
         if (rst || flush)
            cnt[r] <= '0;
         else if (load && (iss_wreg == REG_AW'(r)))
            cnt[r] <= lat_ld;
         else if (cnt[r] != '0)
            cnt[r] <= cnt[r] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 1'b1;
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic,
// all compared against a simple per-register countdown model.
module tb_fwd_hazard_unit;

   localparam int AW = 5;
   localparam int NS = 2;
   localparam int ML = 4;
   localparam int CW = 4;
   localparam int LW = $clog2(ML + 1);
   localparam int SAT = (1 << CW) - 1;

`ifdef FWD_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, flush, ex_valid;
   logic [NS*AW-1:0]  ex_src;
   logic              mem_regwrite, wb_regwrite, iss_valid;
   logic [AW-1:0]     mem_wreg, wb_wreg, iss_wreg;
   logic [LW-1:0]     iss_lat;
   logic [2*NS-1:0]   fwd_sel;
   logic              stall;
   logic [CW-1:0]     stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;
   int sb [32];
   int sc;

   always #5 clk = ~clk;

   fwd_hazard_unit #(
      .REG_AW(AW), .NUM_SRC(NS), .MAX_LAT(ML), .STALL_CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
      .ex_src(ex_src), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
      .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .iss_valid(iss_valid),
      .iss_wreg(iss_wreg), .iss_lat(iss_lat), .fwd_sel(fwd_sel),
      .stall(stall), .stall_cycles(stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int src_of(input int i);
      return int'(ex_src[i*AW +: AW]);
   endfunction

   function automatic bool_zero(input int r);
      return ZERO_EN && r == 0;
   endfunction

   function automatic int exp_sel(input int s);
      if (mem_regwrite && int'(mem_wreg) == s && !bool_zero(s)) return 2;
      if (wb_regwrite && int'(wb_wreg) == s && !bool_zero(s)) return 1;
      return 0;
   endfunction

   function automatic bit exp_stall();
      if (!ex_valid) return 1'b0;
      for (int i = 0; i < NS; i++)
         if (sb[src_of(i)] > 0 && !bool_zero(src_of(i))) return 1'b1;
      return 1'b0;
   endfunction

   // compare outputs mid-cycle, then advance the model across the edge
   task automatic step();
      bit st;
      @(negedge clk);
      st = exp_stall();
      check("stall", {31'b0, stall}, {31'b0, st});
      for (int i = 0; i < NS; i++)
         check($sformatf("fwd_sel%0d", i), {30'b0, fwd_sel[2*i +: 2]},
               exp_sel(src_of(i)));
      check("stall_cycles", {28'b0, stall_cycles}, sc);
      if (rst) begin
         foreach (sb[r]) sb[r] = 0;
         sc = 0;
      end else begin
         if (st && sc < SAT) sc++;
         if (flush) begin
            foreach (sb[r]) sb[r] = 0;
         end else begin
            foreach (sb[r]) if (sb[r] > 0) sb[r]--;
            if (iss_valid && !st && !bool_zero(int'(iss_wreg)))
               sb[iss_wreg] = (int'(iss_lat) > ML) ? ML : int'(iss_lat);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; flush = 0; ex_valid = 0; ex_src = '0;
      mem_regwrite = 0; mem_wreg = '0; wb_regwrite = 0; wb_wreg = '0;
      iss_valid = 0; iss_wreg = '0; iss_lat = '0;
   endtask

   task automatic set_src(input int s0, input int s1);
      ex_src = {AW'(s1), AW'(s0)};
   endtask

   task automatic issue(input int r, input int lat);
      iss_valid = 1; iss_wreg = AW'(r); iss_lat = LW'(lat);
   endtask

   initial begin
      foreach (sb[r]) sb[r] = 0;
      sc = 0;
      idle();
      rst = 1;
      @(posedge clk); #1;
      step(); step();
      rst = 0;
      step();
      check("reset_sc", {28'b0, stall_cycles}, 0);

      // forwarding priority
      mem_regwrite = 1; mem_wreg = 3; wb_regwrite = 1; wb_wreg = 3;
      set_src(3, 7); #1;
      check("prio_mem", {28'b0, fwd_sel}, 32'h2);
      step();
      mem_regwrite = 0; #1;
      check("prio_wb", {28'b0, fwd_sel}, 32'h1);
      step();
      idle();

      // multi-cycle stall on r5
      issue(5, 3); step();
      idle(); ex_valid = 1; set_src(5, 0);
      for (int k = 0; k < 4; k++) step();
      check("sc_after_lat3", {28'b0, stall_cycles}, 3);
      mem_regwrite = 1; mem_wreg = 5; #1;
      check("mem_pickup", {30'b0, fwd_sel[1:0]}, 2);
      step();

      // clamp, collision, suppression
      idle(); issue(5, 7); step();
      idle(); ex_valid = 1; set_src(5, 0);
      for (int k = 0; k < 5; k++) step();
      idle(); issue(5, 2); step();
      idle(); step();
      issue(5, 2); step();
      idle(); ex_valid = 1; set_src(5, 0); issue(8, 3);
      step(); step();
      idle(); ex_valid = 1; set_src(8, 5); step();

      // flush beats a simultaneous issue
      idle(); issue(9, 3); step();
      idle(); flush = 1; issue(10, 4); step();
      idle(); ex_valid = 1; set_src(9, 10); #1;
      check("flush_clear", {31'b0, stall}, 0);
      step();

      // zero register
      idle(); mem_regwrite = 1; mem_wreg = 0; set_src(0, 0); #1;
      check("zero_fwd", {30'b0, fwd_sel[1:0]}, ZERO_EN ? 0 : 2);
      issue(0, 2); step();
      idle(); ex_valid = 1; set_src(0, 0);
      for (int k = 0; k < 3; k++) step();

      // saturation then reset mid-stall
      idle(); ex_valid = 1; set_src(6, 6); issue(6, 7);
      for (int k = 0; k < 30; k++) step();
      check("saturated", {28'b0, stall_cycles}, SAT);
      rst = 1; step();
      rst = 0; #1;
      check("rst_stall", {31'b0, stall}, 0);
      check("rst_sc", {28'b0, stall_cycles}, 0);
      step();

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         rst          = ($urandom_range(0, 99) == 0);
         flush        = ($urandom_range(0, 39) == 0);
         ex_valid     = ($urandom_range(0, 9) < 7);
         set_src($urandom_range(0, 7), $urandom_range(0, 7));
         mem_regwrite = $urandom_range(0, 1);
         mem_wreg     = AW'($urandom_range(0, 7));
         wb_regwrite  = $urandom_range(0, 1);
         wb_wreg      = AW'($urandom_range(0, 7));
         iss_valid    = ($urandom_range(0, 9) < 4);
         iss_wreg     = AW'($urandom_range(0, 7));
         iss_lat      = LW'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
